input_debouncer: RTL and testbench

//  Conditions the raw external input pins before they reach the control module's input_io bus.

---
 rtl/input_debouncer.sv | 98 +++++++++
 tb/tb_input_debouncer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Input conditioning for the control module: 2-FF synchroniser, shared prescaled
// sample tick, and a per-bit consecutive-sample qualifier with a one-cycle change report.
module input_debouncer #(
    parameter int unsigned          INPUTS       = 32,
    parameter int unsigned          STABLE_COUNT = 4,
    parameter int unsigned          CNT_WIDTH    = 3,
    parameter logic [INPUTS-1:0]    RESET_VALUE  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [15:0]       preescalar_value,
    input  logic [INPUTS-1:0] raw_io,
    output logic [INPUTS-1:0] filtered_io,
    output logic [INPUTS-1:0] change_mask,
    output logic              change_valid,
    output logic              tick
);

    localparam int unsigned PCNT_WIDTH = 16;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic [INPUTS-1:0]                 sync1;
    logic [INPUTS-1:0]                 sync2;
    logic [PCNT_WIDTH-1:0]             pcnt;
    logic [PCNT_WIDTH-1:0]             pcnt_d;
    logic                              tick_d;
    logic [INPUTS-1:0][CNT_WIDTH-1:0]  cnt;
    logic [INPUTS-1:0][CNT_WIDTH-1:0]  cnt_d;
    logic [INPUTS-1:0]                 filtered_d;
    logic [INPUTS-1:0]                 mask_d;

    // Synchroniser runs regardless of enable so the sampled value is never stale
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RESET_VALUE;
            sync2 <= RESET_VALUE;
        end else begin
            sync1 <= raw_io;
            sync2 <= sync1;
        end
    end

    // Next-state: prescaler and per-bit qualification counters
    always_comb begin
        pcnt_d     = pcnt;
        tick_d     = 1'b0;
        cnt_d      = cnt;
        filtered_d = filtered_io;
        mask_d     = '0;

        if (!enable) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end else begin
            // >= rather than == so lowering the period mid-count wraps immediately
            if (pcnt >= preescalar_value) begin
                pcnt_d = '0;
                tick_d = 1'b1;
            end else begin
                pcnt_d = pcnt + PCNT_WIDTH'(1);
            end

            if (tick) begin
                for (int unsigned i = 0; i < INPUTS; i++) begin
                    if (sync2[i] == filtered_io[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        filtered_d[i] = sync2[i];
                        cnt_d[i]      = '0;
                        mask_d[i]     = 1'b1;
                    end else begin
                        cnt_d[i] = cnt[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt         <= '0;
            tick         <= 1'b0;
            cnt          <= '0;
            filtered_io  <= RESET_VALUE;
            change_mask  <= '0;
            change_valid <= 1'b0;
        end else begin
            pcnt         <= pcnt_d;
            tick         <= tick_d;
            cnt          <= cnt_d;
            filtered_io  <= filtered_d;
            change_mask  <= mask_d;
            change_valid <= |mask_d;
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: expected filter updates are queued with their
// clock edge and matched against the change report as it appears.
module tb_input_debouncer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] preescalar_value;
    logic [31:0] raw_io;
    logic [31:0] filtered_io;
    logic [31:0] change_mask;
    logic        change_valid;
    logic        tick;

    input_debouncer dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .preescalar_value (preescalar_value),
        .raw_io           (raw_io),
        .filtered_io      (filtered_io),
        .change_mask      (change_mask),
        .change_valid     (change_valid),
        .tick             (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] at;
        logic [31:0] mask;
        logic [31:0] filt;
    } exp_t;

    exp_t        sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] edges  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_change(input logic [31:0] at, input logic [31:0] mask,
                                 input logic [31:0] filt);
        exp_t e;
        e.at = at; e.mask = mask; e.filt = filt;
        sb.push_back(e);
    endtask

    // Advance one clock; sample on the falling edge and service the scoreboard
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        edges = edges + 32'd1;
        @(negedge clk);
        if (change_valid === 1'b1 || change_mask !== 32'h0) begin
            chk("valid_vs_mask", {31'b0, change_valid}, {31'b0, |change_mask});
            if (sb.size() == 0) begin
                chk("unexpected_change", change_mask, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("change_edge", edges, e.at);
                chk("change_mask", change_mask, e.mask);
                chk("change_filt", filtered_io, e.filt);
            end
        end else if (sb.size() != 0 && sb[0].at < edges) begin
            e = sb.pop_front();
            chk("missing_change", change_mask, e.mask);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wait_tick(input int budget, input string tag);
        int k;
        k = 0;
        while (tick !== 1'b1 && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, {31'b0, tick}, 32'h1);
    endtask

    initial begin
        logic [31:0] base;

        // Reset held three cycles with all pins high
        rst = 1'b1; enable = 1'b1; preescalar_value = 16'd9; raw_io = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("rst_filtered", filtered_io, 32'h0);
            chk("rst_mask", change_mask, 32'h0);
            chk("rst_tick", {31'b0, tick}, 32'h0);
        end
        rst = 1'b0; raw_io = 32'h0;
        cycle();
        chk("post_rst_filtered", filtered_io, 32'h0);
        chk("post_rst_mask", change_mask, 32'h0);
        chk("post_rst_tick", {31'b0, tick}, 32'h0);

        // Single-bit step, tick every cycle: update on the 6th edge
        preescalar_value = 16'd0;
        run(4);
        raw_io = 32'h1;
        expect_change(edges + 32'd6, 32'h1, 32'h1);
        run(8);
        chk("step_bit0", filtered_io, 32'h1);

        // Periodic one-cycle glitches on bit 5 must never qualify
        for (int g = 0; g < 8; g++) begin
            raw_io = 32'h21;
            cycle();
            raw_io = 32'h1;
            run(2);
        end
        run(4);
        chk("glitch_bit5", filtered_io, 32'h1);

        // Falling step on bit 0
        raw_io = 32'h0;
        expect_change(edges + 32'd6, 32'h1, 32'h0);
        run(8);
        chk("fall_bit0", filtered_io, 32'h0);

        // Prescaled ticks every 10 cycles; multi-bit step reported in one mask
        preescalar_value = 16'd9;
        wait_tick(30, "presc9_first_tick");
        for (int k = 1; k <= 10; k++) begin
            cycle();
            chk("presc9_period", {31'b0, tick}, {31'b0, k == 10});
        end
        raw_io = 32'hA5A5_0000;
        expect_change(edges + 32'd41, 32'hA5A5_0000, 32'hA5A5_0000);
        run(45);
        chk("multi_bit", filtered_io, 32'hA5A5_0000);

        // Lowering the period mid-count wraps on the next edge
        preescalar_value = 16'd1000;
        wait_tick(1100, "presc1000_tick");
        run(500);
        chk("mid_count_no_tick", {31'b0, tick}, 32'h0);
        preescalar_value = 16'd100;
        cycle();
        chk("wrap_tick", {31'b0, tick}, 32'h1);
        for (int k = 1; k <= 101; k++) begin
            cycle();
            chk("presc100_period", {31'b0, tick}, {31'b0, k == 101});
        end

        // Disable after two qualifying ticks on bit 3: counts discarded
        preescalar_value = 16'd0;
        run(3);
        raw_io = 32'hA5A5_0008;
        run(4);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("disabled_hold", filtered_io, 32'hA5A5_0000);
            chk("disabled_tick", {31'b0, tick}, 32'h0);
        end
        enable = 1'b1;
        base = edges;
        cycle();
        chk("reenable_tick", {31'b0, tick}, 32'h1);
        expect_change(base + 32'd5, 32'h8, 32'hA5A5_0008);
        run(8);
        chk("reenable_bit3", filtered_io, 32'hA5A5_0008);

        // Reset mid-qualification returns to the reset value, then requalifies
        raw_io = 32'hA5A5_000A;
        run(4);
        rst = 1'b1;
        cycle();
        chk("midq_rst_filtered", filtered_io, 32'h0);
        chk("midq_rst_mask", change_mask, 32'h0);
        rst = 1'b0;
        expect_change(edges + 32'd6, 32'hA5A5_000A, 32'hA5A5_000A);
        run(9);
        chk("requalified", filtered_io, 32'hA5A5_000A);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
